// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a memory-mapped UART store and an AXI-stream UART transmitter.
// Drops bytes when full (unless a pop frees a slot the same edge) and keeps a sticky/saturating drop record.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [7:0]               i_write_uart,
    input  logic                     i_write_uart_en,
    output logic [7:0]               o_data,
    output logic                     o_valid,
    input  logic                     i_out_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_cnt,
    input  logic                     i_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    drop_cnt;

    logic push_req;
    logic push_ok;
    logic pop;
    logic drop;
    logic full;
    logic valid;

    always_comb begin
        full     = (count == CW'(DEPTH));
        valid    = (count != '0);
        push_req = i_write_uart_en && clk_en;
        pop      = valid && i_out_ready;
        // a pop on the same edge frees the slot a full FIFO needs
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_write_uart;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // a drop coinciding with clear restarts the record at one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (i_clear) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (i_clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    always_comb begin
        o_valid    = valid;
        o_empty    = !valid;
        o_full     = full;
        o_count    = count;
        o_data     = valid ? mem[rd_ptr] : 8'h00;
        o_overflow = overflow;
        o_drop_cnt = drop_cnt;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, 2..256.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low (0 = in reset).
REQ-004 SHALL have port clk_en  input  1  qualifies the write side only.
REQ-005 SHALL have port i_write_uart  input  8  byte from the memory-mapped UART store in RAM.
REQ-006 SHALL have port i_write_uart_en  input  1  byte-write strobe, one byte per high cycle.
REQ-007 SHALL have port o_data  output  8  AXI-stream byte toward the UART transmitter.
REQ-008 SHALL have port o_valid  output  1  AXI-stream valid.
REQ-009 SHALL have port i_out_ready  input  1  AXI-stream ready from the UART transmitter.
REQ-010 SHALL have port o_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port o_full  output  1  occupancy == DEPTH.
REQ-012 SHALL have port o_empty  output  1  occupancy == 0.
REQ-013 SHALL have port o_overflow  output  1  sticky: at least one byte dropped.
REQ-014 SHALL have port o_drop_cnt  output  8  dropped-byte count, saturating.
REQ-015 SHALL have port i_clear  input  1  synchronous clear of o_overflow and o_drop_cnt.

Function
REQ-016 Push request SHALL be i_write_uart_en && clk_en sampled at a rising edge.
REQ-017 Pop SHALL occur at an edge where o_valid && i_out_ready; not gated by clk_en.
REQ-018 Push SHALL be accepted when count < DEPTH, or when count == DEPTH and a pop occurs the same edge.
REQ-019 Accepted push SHALL write i_write_uart at write pointer; pointer increments mod DEPTH.
REQ-020 Pop SHALL advance read pointer mod DEPTH.
REQ-021 Count: +1 push only, -1 pop only, unchanged on push+pop or neither.
REQ-022 o_valid SHALL be 1 exactly when count > 0; o_empty = !o_valid.
REQ-023 o_data SHALL equal the entry at read pointer while o_valid = 1, and 8'h00 while o_valid = 0.
REQ-024 Latency: byte pushed into an empty FIFO at edge N SHALL present o_valid = 1 in the cycle after edge N.
REQ-025 While o_valid = 1 and i_out_ready = 0, o_data SHALL remain stable.
REQ-026 Bytes SHALL leave in push order; no duplication, no reordering.
REQ-027 Push to empty FIFO with i_out_ready = 1 SHALL NOT pop in the same edge (no bypass).
REQ-028 Rejected push (full, no pop) SHALL drop the byte, set o_overflow, increment o_drop_cnt saturating at 255.
REQ-029 i_clear at an edge SHALL zero o_overflow and o_drop_cnt; coincident drop wins: o_overflow = 1, o_drop_cnt = 1.
REQ-030 i_write_uart_en with clk_en = 0 SHALL be ignored entirely (no push, no drop).

Reset
REQ-031 rst = 0 SHALL immediately force pointers 0, count 0, o_valid 0, o_data 8'h00, o_empty 1, o_full 0, o_overflow 0, o_drop_cnt 0.
REQ-032 Reset mid-transfer SHALL discard all stored bytes; memory contents need not be cleared.
REQ-033 First push SHALL be accepted at the first rising edge after rst returns to 1.

Verification
REQ-034 Bench: push 8'h41 into empty, i_out_ready = 1 -> o_valid = 1 next cycle with o_data = 8'h41, popped the following edge, o_empty = 1.
REQ-035 Bench: push 16 bytes 8'h00..8'h0F with i_out_ready = 0 -> o_full = 1, o_count = 16; release ready -> bytes 00..0F out in order, one per cycle.
REQ-036 Bench: full, push 3 more with ready = 0 -> o_overflow = 1, o_drop_cnt = 3, contents 00..0F intact; i_clear -> both zero.
REQ-037 Bench: full, push 8'hAA concurrent with pop -> o_count stays 16, no overflow, 8'hAA emerges last after 15 more pops.
REQ-038 Bench: i_write_uart_en = 1 with clk_en = 0 for 5 cycles -> o_count stays 0, o_drop_cnt 0.
REQ-039 Bench: 20 pushes wrapping pointers, then rst = 0 asynchronously mid-cycle -> o_valid falls without a clock edge, o_count = 0.
